// File: rtl/id_ex_pkg.sv
// Shared constants and types for the ID->EX pipeline register: default bus widths,
// instruction field positions and the stage state encoding.
package id_ex_pkg;

  localparam int LEN_DATA_DEF     = 32;
  localparam int NUM_BITS_DEF     = 5;
  localparam int LEN_EXEC_BUS_DEF = 11;
  localparam int LEN_MEM_BUS_DEF  = 9;
  localparam int LEN_WB_BUS_DEF   = 2;
  localparam int MEM_READ_BIT_DEF = 1;

  localparam int RS_LSB    = 21;
  localparam int RT_LSB    = 16;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_LSB = 6;
  localparam int IMM_W     = 16;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    HALT  = 2'd2
  } state_t;

endpackage

// File: rtl/id_ex_pipe_reg_if.sv
// Decode->execute handshake bundle: decode-side entry with valid/ready, execute-side registered entry.
interface id_ex_pipe_reg_if
  import id_ex_pkg::*;
#(
  parameter int LEN_DATA     = LEN_DATA_DEF,
  parameter int NUM_BITS     = NUM_BITS_DEF,
  parameter int LEN_EXEC_BUS = LEN_EXEC_BUS_DEF,
  parameter int LEN_MEM_BUS  = LEN_MEM_BUS_DEF,
  parameter int LEN_WB_BUS   = LEN_WB_BUS_DEF
);

  logic                    in_valid;
  logic                    in_ready;
  logic [LEN_DATA-1:0]     in_pc_branch;
  logic [LEN_DATA-1:0]     in_instr;
  logic [LEN_DATA-1:0]     in_reg1;
  logic [LEN_DATA-1:0]     in_reg2;
  logic [LEN_EXEC_BUS-1:0] in_exec_bus;
  logic [LEN_MEM_BUS-1:0]  in_mem_bus;
  logic [LEN_WB_BUS-1:0]   in_wb_bus;

  logic                    out_ready;
  logic                    out_valid;
  logic [LEN_DATA-1:0]     out_pc_branch;
  logic [LEN_DATA-1:0]     out_reg1;
  logic [LEN_DATA-1:0]     out_reg2;
  logic [LEN_DATA-1:0]     out_sign_extend;
  logic [NUM_BITS-1:0]     out_rs;
  logic [NUM_BITS-1:0]     out_rt;
  logic [NUM_BITS-1:0]     out_rd;
  logic [NUM_BITS-1:0]     out_shamt;
  logic [LEN_EXEC_BUS-1:0] execute_bus;
  logic [LEN_MEM_BUS-1:0]  memory_bus;
  logic [LEN_WB_BUS-1:0]   writeBack_bus;

  modport master (
    output in_valid, in_pc_branch, in_instr, in_reg1, in_reg2,
           in_exec_bus, in_mem_bus, in_wb_bus, out_ready,
    input  in_ready, out_valid, out_pc_branch, out_reg1, out_reg2, out_sign_extend,
           out_rs, out_rt, out_rd, out_shamt, execute_bus, memory_bus, writeBack_bus
  );

  modport slave (
    input  in_valid, in_pc_branch, in_instr, in_reg1, in_reg2,
           in_exec_bus, in_mem_bus, in_wb_bus, out_ready,
    output in_ready, out_valid, out_pc_branch, out_reg1, out_reg2, out_sign_extend,
           out_rs, out_rt, out_rd, out_shamt, execute_bus, memory_bus, writeBack_bus
  );

endinterface

// File: rtl/load_use_detect.sv
// Combinational load-use compare: a pending load's rt against the incoming rs/rt.
// Register 0 never creates a dependency.
module load_use_detect #(
  parameter int NUM_BITS = 5
) (
  input  logic                ld_pending,
  input  logic                in_valid,
  input  logic [NUM_BITS-1:0] cmp_rt,
  input  logic [NUM_BITS-1:0] src_rs,
  input  logic [NUM_BITS-1:0] src_rt,
  output logic                hazard
);

  assign hazard = ld_pending & in_valid & (cmp_rt != '0) &
                  ((cmp_rt == src_rs) | (cmp_rt == src_rt));

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID->EX register, 1-cycle latency; holds while execute back-pressures, drops in_ready during
// load-use bubbles and after a halt. `ID_EX_PERF_CNT_EN adds saturating stall/flush counters.
module id_ex_pipe_reg
  import id_ex_pkg::*;
#(
  parameter int LEN_DATA        = LEN_DATA_DEF,
  parameter int NUM_BITS        = NUM_BITS_DEF,
  parameter int LEN_EXEC_BUS    = LEN_EXEC_BUS_DEF,
  parameter int LEN_MEM_BUS     = LEN_MEM_BUS_DEF,
  parameter int LEN_WB_BUS      = LEN_WB_BUS_DEF,
  parameter int MEM_READ_BIT    = MEM_READ_BIT_DEF,
  parameter int LOAD_USE_STALLS = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ctrl_clk_mips,
  input  logic             flush,
  input  logic             halt_flag_d,
  id_ex_pipe_reg_if.slave  bus,
  output logic             out_halt_flag_d,
  output logic             stall_flag
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [15:0]      perf_stall_cnt,
  output logic [15:0]      perf_flush_cnt
`endif
);

  localparam logic [2:0] STALL_INIT = 3'(LOAD_USE_STALLS - 1);

  state_t                  state_q, state_d;
  logic [2:0]              cnt_q, cnt_d;
  logic [NUM_BITS-1:0]     hz_rt_q, hz_rt_d;

  logic                    valid_q;
  logic [LEN_DATA-1:0]     pc_q, reg1_q, reg2_q, se_q;
  logic [NUM_BITS-1:0]     rs_q, rt_q, rd_q, shamt_q;
  logic [LEN_EXEC_BUS-1:0] exec_q;
  logic [LEN_MEM_BUS-1:0]  mem_q;
  logic [LEN_WB_BUS-1:0]   wb_q;
  logic                    halt_q;

  logic                    advance, hazard, ld_pending, load_entry, load_bubble;
  logic [NUM_BITS-1:0]     cmp_rt, in_rs, in_rt;
  logic [LEN_DATA-1:0]     in_se;
  logic                    unused_instr_hi;

  assign advance = ctrl_clk_mips & (bus.out_ready | ~valid_q);
  assign in_rs   = bus.in_instr[RS_LSB +: NUM_BITS];
  assign in_rt   = bus.in_instr[RT_LSB +: NUM_BITS];
  assign in_se   = {{(LEN_DATA-IMM_W){bus.in_instr[IMM_W-1]}}, bus.in_instr[IMM_W-1:0]};
  assign unused_instr_hi = ^bus.in_instr[LEN_DATA-1:RS_LSB+NUM_BITS];

  // While stalling the load has left the output; its rt is remembered in hz_rt.
  assign ld_pending = (state_q == STALL) | (valid_q & mem_q[MEM_READ_BIT]);
  assign cmp_rt     = (state_q == STALL) ? hz_rt_q : rt_q;

  load_use_detect #(.NUM_BITS(NUM_BITS)) u_load_use_detect (
    .ld_pending (ld_pending),
    .in_valid   (bus.in_valid),
    .cmp_rt     (cmp_rt),
    .src_rs     (in_rs),
    .src_rt     (in_rt),
    .hazard     (hazard)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
      hz_rt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hz_rt_q <= hz_rt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hz_rt_d      = hz_rt_q;
    load_entry   = 1'b0;
    load_bubble  = 1'b0;
    stall_flag   = 1'b0;
    bus.in_ready = 1'b0;
    case (state_q)
      RUN: begin
        bus.in_ready = advance & (flush | ~hazard);
        stall_flag   = hazard & ~flush;
        if (advance) begin
          if (flush) begin
            load_bubble = 1'b1;
          end else if (hazard) begin
            load_bubble = 1'b1;
            cnt_d       = STALL_INIT;
            hz_rt_d     = rt_q;
            if (STALL_INIT != 3'd0) state_d = STALL;
          end else if (bus.in_valid) begin
            load_entry = 1'b1;
            if (halt_flag_d) state_d = HALT;
          end else begin
            load_bubble = 1'b1;
          end
        end
      end
      STALL: begin
        stall_flag = ~flush;
        if (advance) begin
          load_bubble = 1'b1;
          if (flush) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - 3'd1;
            if (cnt_q == 3'd1) state_d = RUN;
          end
        end
      end
      HALT: begin
        // Drain only: the halted entry leaves, bubbles follow until reset.
        if (advance) load_bubble = 1'b1;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      reg1_q  <= '0;
      reg2_q  <= '0;
      se_q    <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
      shamt_q <= '0;
      exec_q  <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      halt_q  <= 1'b0;
    end else if (load_entry) begin
      valid_q <= 1'b1;
      pc_q    <= bus.in_pc_branch;
      reg1_q  <= bus.in_reg1;
      reg2_q  <= bus.in_reg2;
      se_q    <= in_se;
      rs_q    <= in_rs;
      rt_q    <= in_rt;
      rd_q    <= bus.in_instr[RD_LSB +: NUM_BITS];
      shamt_q <= bus.in_instr[SHAMT_LSB +: NUM_BITS];
      exec_q  <= bus.in_exec_bus;
      mem_q   <= bus.in_mem_bus;
      wb_q    <= bus.in_wb_bus;
      if (halt_flag_d) halt_q <= 1'b1;
    end else if (load_bubble) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      reg1_q  <= '0;
      reg2_q  <= '0;
      se_q    <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
      shamt_q <= '0;
      exec_q  <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
    end
  end

  assign bus.out_valid       = valid_q;
  assign bus.out_pc_branch   = pc_q;
  assign bus.out_reg1        = reg1_q;
  assign bus.out_reg2        = reg2_q;
  assign bus.out_sign_extend = se_q;
  assign bus.out_rs          = rs_q;
  assign bus.out_rt          = rt_q;
  assign bus.out_rd          = rd_q;
  assign bus.out_shamt       = shamt_q;
  assign bus.execute_bus     = exec_q;
  assign bus.memory_bus      = mem_q;
  assign bus.writeBack_bus   = wb_q;
  assign out_halt_flag_d     = halt_q;

`ifdef ID_EX_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (advance && stall_flag && perf_stall_cnt != 16'hFFFF)
        perf_stall_cnt <= perf_stall_cnt + 16'd1;
      if (advance && flush && perf_flush_cnt != 16'hFFFF)
        perf_flush_cnt <= perf_flush_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed bench for id_ex_pipe_reg (LOAD_USE_STALLS=2) with an output scoreboard.
module tb_id_ex_pipe_reg;

  logic clk = 1'b0;
  logic reset_n, ctrl_clk_mips, flush, halt_flag_d, out_halt_flag_d, stall_flag;
`ifdef ID_EX_PERF_CNT_EN
  logic [15:0] perf_stall_cnt, perf_flush_cnt;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [31:0] pc, r1, r2, se;
    logic [4:0]  rs, rt, rd, sh;
    logic [10:0] ex;
    logic [8:0]  mem;
    logic [1:0]  wb;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  id_ex_pipe_reg_if bus ();

  id_ex_pipe_reg #(.LOAD_USE_STALLS(2)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .ctrl_clk_mips   (ctrl_clk_mips),
    .flush           (flush),
    .halt_flag_d     (halt_flag_d),
    .bus             (bus),
    .out_halt_flag_d (out_halt_flag_d),
    .stall_flag      (stall_flag)
`ifdef ID_EX_PERF_CNT_EN
    ,
    .perf_stall_cnt  (perf_stall_cnt),
    .perf_flush_cnt  (perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  function automatic logic [31:0] r_ins(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    return {6'd0, rs, rt, rd, 5'd0, 6'h20};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic drive(input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] r1,
                       input logic [31:0] r2, input logic [8:0] mem, input bit push);
    exp_t e;
    bus.in_valid     = 1'b1;
    bus.in_pc_branch = pc;
    bus.in_instr     = instr;
    bus.in_reg1      = r1;
    bus.in_reg2      = r2;
    bus.in_exec_bus  = 11'h155;
    bus.in_mem_bus   = mem;
    bus.in_wb_bus    = 2'b10;
    if (push) begin
      e.pc  = pc;
      e.r1  = r1;
      e.r2  = r2;
      e.se  = {{16{instr[15]}}, instr[15:0]};
      e.rs  = instr[25:21];
      e.rt  = instr[20:16];
      e.rd  = instr[15:11];
      e.sh  = instr[10:6];
      e.ex  = 11'h155;
      e.mem = mem;
      e.wb  = 2'b10;
      sb.push_back(e);
    end
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    halt_flag_d  = 1'b0;
  endtask

  // Scoreboard: every transfer to execute must match the oldest accepted entry.
  always @(negedge clk) begin
    if (reset_n && ctrl_clk_mips && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        chk("sb_extra_valid", {31'd0, bus.out_valid}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("sb_pc", bus.out_pc_branch, mon_e.pc);
        chk("sb_fields", {12'd0, bus.out_rs, bus.out_rt, bus.out_rd, bus.out_shamt},
            {12'd0, mon_e.rs, mon_e.rt, mon_e.rd, mon_e.sh});
        chk("sb_sign_extend", bus.out_sign_extend, mon_e.se);
        chk("sb_reg1", bus.out_reg1, mon_e.r1);
        chk("sb_reg2", bus.out_reg2, mon_e.r2);
        chk("sb_ctrl", {10'd0, bus.execute_bus, bus.memory_bus, bus.writeBack_bus},
            {10'd0, mon_e.ex, mon_e.mem, mon_e.wb});
      end
    end
  end

  initial begin
    reset_n = 1'b1;
    ctrl_clk_mips = 1'b1;
    flush = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_pc_branch = '0;
    bus.in_instr = '0;
    bus.in_reg1 = '0;
    bus.in_reg2 = '0;
    bus.in_exec_bus = '0;
    bus.in_mem_bus = '0;
    bus.in_wb_bus = '0;
    idle();
    #1 reset_n = 1'b0;
    #2;
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_stall_flag", {31'd0, stall_flag}, 32'd0);
    chk("rst_halt", {31'd0, out_halt_flag_d}, 32'd0);
    chk("rst_sign_extend", bus.out_sign_extend, 32'd0);
    cyc();
    reset_n = 1'b1;
    at_neg();
    cyc();

    // add r3,r1,r2 appears one cycle later
    drive(32'h104, r_ins(5'd1, 5'd2, 5'd3), 32'h11, 32'h22, 9'h000, 1'b1);
    at_neg();
    chk("t1_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("t1_stall", {31'd0, stall_flag}, 32'd0);
    cyc();
    idle();
    at_neg();
    chk("t1_out_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("t1_rd_rs_rt", {17'd0, bus.out_rd, bus.out_rs, bus.out_rt}, {17'd0, 5'd3, 5'd1, 5'd2});
    cyc();

    // lw r5 then dependent add r6,r5,r1: two stall cycles
    drive(32'h108, i_ins(6'h23, 5'd2, 5'd5, 16'h0010), 32'h1000, 32'h0, 9'h002, 1'b1);
    at_neg();
    cyc();
    drive(32'h10C, r_ins(5'd5, 5'd1, 5'd6), 32'h55, 32'h66, 9'h000, 1'b0);
    at_neg();
    chk("t2_stall_c1", {31'd0, stall_flag}, 32'd1);
    chk("t2_in_ready_c1", {31'd0, bus.in_ready}, 32'd0);
    cyc();
    at_neg();
    chk("t2_stall_c2", {31'd0, stall_flag}, 32'd1);
    chk("t2_in_ready_c2", {31'd0, bus.in_ready}, 32'd0);
    chk("t2_bubble", {31'd0, bus.out_valid}, 32'd0);
    cyc();
    drive(32'h10C, r_ins(5'd5, 5'd1, 5'd6), 32'h55, 32'h66, 9'h000, 1'b1);
    at_neg();
    chk("t2_stall_c3", {31'd0, stall_flag}, 32'd0);
    chk("t2_in_ready_c3", {31'd0, bus.in_ready}, 32'd1);
    cyc();
    idle();
    at_neg();
    chk("t2_add_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("t2_add_rd", {27'd0, bus.out_rd}, 32'd6);
    cyc();

    // flush during the stall cancels it
    drive(32'h110, i_ins(6'h23, 5'd3, 5'd7, 16'h0020), 32'h2000, 32'h0, 9'h002, 1'b1);
    at_neg();
    cyc();
    drive(32'h114, r_ins(5'd7, 5'd7, 5'd8), 32'h77, 32'h77, 9'h000, 1'b0);
    at_neg();
    chk("t3_stall_hz", {31'd0, stall_flag}, 32'd1);
    cyc();
    flush = 1'b1;
    at_neg();
    chk("t3_stall_flushed", {31'd0, stall_flag}, 32'd0);
    chk("t3_in_ready_stall", {31'd0, bus.in_ready}, 32'd0);
    cyc();
    flush = 1'b0;
    idle();
    at_neg();
    chk("t3_stall_after", {31'd0, stall_flag}, 32'd0);
    chk("t3_in_ready_after", {31'd0, bus.in_ready}, 32'd1);
    chk("t3_out_valid", {31'd0, bus.out_valid}, 32'd0);
    cyc();

    // back-pressure for 3 cycles holds a negative immediate; flush without advance is ignored
    drive(32'h200, i_ins(6'h08, 5'd1, 5'd9, 16'hFFFC), 32'h9, 32'h0, 9'h000, 1'b1);
    at_neg();
    cyc();
    idle();
    bus.out_ready = 1'b0;
    at_neg();
    chk("t4_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("t4_sign_extend", bus.out_sign_extend, 32'hFFFFFFFC);
    chk("t4_in_ready", {31'd0, bus.in_ready}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      cyc();
      if (i == 1) flush = 1'b1;
      at_neg();
      chk("t4_hold_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("t4_hold_se", bus.out_sign_extend, 32'hFFFFFFFC);
      chk("t4_hold_rt", {27'd0, bus.out_rt}, 32'd9);
    end
    cyc();
    flush = 1'b0;
    bus.out_ready = 1'b1;
    at_neg();
    chk("t4_flush_no_adv", {31'd0, bus.out_valid}, 32'd1);
    cyc();
    at_neg();
    chk("t4_drained", {31'd0, bus.out_valid}, 32'd0);
    cyc();

    // clock enable dropped mid-stall freezes the remaining bubble count
    drive(32'h300, i_ins(6'h23, 5'd4, 5'd10, 16'h0004), 32'h3000, 32'h0, 9'h002, 1'b1);
    at_neg();
    cyc();
    drive(32'h304, r_ins(5'd0, 5'd10, 5'd11), 32'h0, 32'hAA, 9'h000, 1'b0);
    at_neg();
    chk("t5_stall_hz", {31'd0, stall_flag}, 32'd1);
    cyc();
    ctrl_clk_mips = 1'b0;
    for (int i = 0; i < 2; i++) begin
      at_neg();
      chk("t5_frozen_stall", {31'd0, stall_flag}, 32'd1);
      chk("t5_frozen_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("t5_frozen_valid", {31'd0, bus.out_valid}, 32'd0);
      cyc();
    end
    ctrl_clk_mips = 1'b1;
    at_neg();
    chk("t5_resume_stall", {31'd0, stall_flag}, 32'd1);
    chk("t5_resume_ready", {31'd0, bus.in_ready}, 32'd0);
    cyc();
    drive(32'h304, r_ins(5'd0, 5'd10, 5'd11), 32'h0, 32'hAA, 9'h000, 1'b1);
    at_neg();
    chk("t5_run_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("t5_run_stall", {31'd0, stall_flag}, 32'd0);
    cyc();
    idle();
    at_neg();
    chk("t5_add_rd", {27'd0, bus.out_rd}, 32'd11);
    cyc();

    // halt entry drains, blocks further input, reset clears everything at once
    drive(32'h400, r_ins(5'd1, 5'd2, 5'd12), 32'h1, 32'h2, 9'h000, 1'b1);
    halt_flag_d = 1'b1;
    at_neg();
    chk("t6_in_ready", {31'd0, bus.in_ready}, 32'd1);
    cyc();
    idle();
    at_neg();
    chk("t6_halt_out", {31'd0, out_halt_flag_d}, 32'd1);
    chk("t6_halt_valid", {31'd0, bus.out_valid}, 32'd1);
    cyc();
    drive(32'h404, r_ins(5'd1, 5'd2, 5'd13), 32'h1, 32'h2, 9'h000, 1'b0);
    for (int i = 0; i < 2; i++) begin
      at_neg();
      chk("t6_halt_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("t6_halt_drain", {31'd0, bus.out_valid}, 32'd0);
      chk("t6_halt_held", {31'd0, out_halt_flag_d}, 32'd1);
      cyc();
    end
`ifdef ID_EX_PERF_CNT_EN
    chk("perf_stall", {16'd0, perf_stall_cnt}, 32'd5);
    chk("perf_flush", {16'd0, perf_flush_cnt}, 32'd1);
`endif
    reset_n = 1'b0;
    idle();
    #1;
    chk("t6_rst_halt", {31'd0, out_halt_flag_d}, 32'd0);
    chk("t6_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("t6_rst_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("t6_rst_stall", {31'd0, stall_flag}, 32'd0);
    chk("t6_rst_rd", {27'd0, bus.out_rd}, 32'd0);
`ifdef ID_EX_PERF_CNT_EN
    chk("t6_rst_perf", {perf_stall_cnt, perf_flush_cnt}, 32'd0);
`endif
    cyc();
    reset_n = 1'b1;
    at_neg();
    chk("sb_drained", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
